// File: rtl/ahb_rtl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_rtl_pkg : AHB-lite transfer/burst encodings and arbiter states    |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package ahb_rtl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ST_PARK  = 2'd0,
    ST_OWN   = 2'd1,
    ST_BURST = 2'd2
  } arb_state_e;

  // Undefined-length INCR counts as one beat; its length is policed separately.
  function automatic logic [4:0] burst_beats(hburst_e burst);
    logic [4:0] beats;
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd1;
    endcase
    return beats;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_lite_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_bus_arbiter_if : request/bus-status/grant bundle            |
// | Revision                : 1.0                                        |
// +----------------------------------------------------------------------+
interface ahb_lite_bus_arbiter_if import ahb_rtl_pkg::*; #(
  parameter int NUM_MASTERS = 4
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] lock;
  htrans_e                HTRANS;
  hburst_e                HBURST;
  logic                   HREADY;
  logic                   HRESP;
  logic [NUM_MASTERS-1:0] grant;
  logic [IDX_W-1:0]       owner;
  logic [IDX_W-1:0]       data_owner;
  logic                   HMASTLOCK;

  // master: requester/bus side; slave: the arbiter itself
  modport master (
    output req, lock, HTRANS, HBURST, HREADY, HRESP,
    input  grant, owner, data_owner, HMASTLOCK
  );

  modport slave (
    input  req, lock, HTRANS, HBURST, HREADY, HRESP,
    output grant, owner, data_owner, HMASTLOCK
  );
endinterface
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_rr_picker : combinational round-robin priority encoder           |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       start_ptr,
  output logic [IDX_W-1:0]       winner,
  output logic                   any_req
);
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk from the far end so the candidate closest to start_ptr is written last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      w_sum  = {1'b0, start_ptr} + (IDX_W+1)'(i);
      w_cand = (w_sum >= (IDX_W+1)'(NUM_MASTERS)) ?
               IDX_W'(w_sum - (IDX_W+1)'(NUM_MASTERS)) : IDX_W'(w_sum);
      if (req[w_cand]) begin
        winner  = w_cand;
        any_req = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/ahb_lite_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ahb_lite_bus_arbiter : burst/lock-aware round-robin AHB-lite arbiter |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module ahb_lite_bus_arbiter import ahb_rtl_pkg::*; #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MAX_INCR_BEATS = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_lite_bus_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_INCR_BEATS);
  localparam logic [IDX_W-1:0]       c_default_idx   = IDX_W'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] c_default_grant = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [CNT_W-1:0]       c_incr_last     = CNT_W'(MAX_INCR_BEATS - 1);

  arb_state_e             state_q, state_d;
  logic [3:0]             beat_rem_q, beat_rem_d;
  logic [CNT_W-1:0]       incr_cnt_q, incr_cnt_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       data_owner_q, data_owner_d;
  logic                   hmastlock_q, hmastlock_d;

  logic [IDX_W-1:0] w_start_ptr;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_winner;
  logic             w_any_req;
  logic [4:0]       w_len;
  logic [3:0]       w_beat_next;
  logic             w_incr_active;
  logic             w_rearb;

  assign w_start_ptr = (owner_q == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_q + IDX_W'(1);

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_picker (
    .req       (bus.req),
    .start_ptr (w_start_ptr),
    .winner    (w_pick),
    .any_req   (w_any_req)
  );

  always_comb begin
    w_len       = burst_beats(bus.HBURST);
    w_beat_next = beat_rem_q;
    case (bus.HTRANS)
      HTRANS_NONSEQ: w_beat_next = 4'(w_len - 5'd1);
      HTRANS_SEQ:    w_beat_next = (beat_rem_q == 4'd0) ? 4'd0 : beat_rem_q - 4'd1;
      HTRANS_IDLE:   w_beat_next = 4'd0;
      default:       w_beat_next = beat_rem_q;
    endcase
    if (bus.HRESP) begin
      w_beat_next = 4'd0;
    end
  end

  assign w_incr_active = (bus.HBURST == HBURST_INCR) && (bus.HTRANS != HTRANS_IDLE);
  assign w_rearb       = !bus.lock[owner_q] && (w_beat_next == 4'd0) &&
                         (!w_incr_active || (incr_cnt_q == c_incr_last));
  assign w_winner      = w_any_req ? w_pick : c_default_idx;

  // Everything freezes while HREADY is low.
  always_comb begin
    state_d      = state_q;
    beat_rem_d   = beat_rem_q;
    incr_cnt_d   = incr_cnt_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    data_owner_d = data_owner_q;
    hmastlock_d  = hmastlock_q;
    if (bus.HREADY) begin
      beat_rem_d   = w_beat_next;
      data_owner_d = owner_q;
      if (w_rearb) begin
        incr_cnt_d  = '0;
        owner_d     = w_winner;
        grant_d     = NUM_MASTERS'(1) << w_winner;
        hmastlock_d = bus.lock[w_winner];
        state_d     = w_any_req ? ST_OWN : ST_PARK;
      end else begin
        if (bus.HTRANS == HTRANS_IDLE) begin
          incr_cnt_d = '0;
        end else if ((bus.HBURST == HBURST_INCR) &&
                     ((bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ))) begin
          // Saturate so a lock held past the limit still hands off once released.
          incr_cnt_d = (incr_cnt_q == c_incr_last) ? incr_cnt_q : incr_cnt_q + CNT_W'(1);
        end
        state_d = ((w_beat_next != 4'd0) || w_incr_active) ? ST_BURST : ST_OWN;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q      <= ST_PARK;
      beat_rem_q   <= 4'd0;
      incr_cnt_q   <= '0;
      grant_q      <= c_default_grant;
      owner_q      <= c_default_idx;
      data_owner_q <= c_default_idx;
      hmastlock_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_rem_q   <= beat_rem_d;
      incr_cnt_q   <= incr_cnt_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      data_owner_q <= data_owner_d;
      hmastlock_q  <= hmastlock_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.owner      = owner_q;
  assign bus.data_owner = data_owner_q;
  assign bus.HMASTLOCK  = hmastlock_q;
endmodule
`default_nettype wire
